// File: rtl/config_loader.sv
// config_loader: clears the tile config chain, then shifts exactly CHAIN_LENGTH bitstream bits into it.
// Optional tail readback check (chain must read back all zeros) built when CONFIG_LOADER_READBACK_EN is defined.
module config_loader #(
  parameter int CHAIN_LENGTH = 36,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  input  logic                  config_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LENGTH - (NUM_WORDS - 1) * WORD_WIDTH;
  localparam int CNT_W     = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W     = $clog2(NUM_WORDS + 1);
  localparam int REM_W     = $clog2(WORD_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  clr_q, clr_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [CNT_W-1:0]      bits_q, bits_d;
  logic                  word_ready_q, word_ready_d;
  logic                  config_out_q, config_out_d;
  logic                  config_enable_q, config_enable_d;
  logic                  config_nreset_q, config_nreset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;

  assign accept = word_valid && word_ready_q;

  // rem_q counts bits still queued behind the one currently on config_out.
  always_comb begin
    state_d         = state_q;
    clr_d           = clr_q;
    shreg_d         = shreg_q;
    rem_d           = rem_q;
    widx_d          = widx_q;
    bits_d          = bits_q;
    config_out_d    = 1'b0;
    config_enable_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          clr_d   = 1'b0;
          rem_d   = '0;
          widx_d  = '0;
          bits_d  = '0;
        end
      end
      S_CLEAR: begin
        clr_d = 1'b1;
        if (clr_q) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bits_q == CNT_W'(CHAIN_LENGTH)) begin
          state_d = S_DONE;
        end else if (accept) begin
          config_out_d    = word_data[0];
          config_enable_d = 1'b1;
          shreg_d         = word_data >> 1;
          // The final word only carries the bits that still fit in the chain.
          rem_d  = (widx_q == IDX_W'(NUM_WORDS - 1)) ? REM_W'(LAST_BITS - 1) : REM_W'(WORD_WIDTH - 1);
          widx_d = widx_q + 1'b1;
          bits_d = bits_q + 1'b1;
        end else if (rem_q != '0) begin
          config_out_d    = shreg_q[0];
          config_enable_d = 1'b1;
          shreg_d         = shreg_q >> 1;
          rem_d           = rem_q - 1'b1;
          bits_d          = bits_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    word_ready_d    = (state_d == S_LOAD) && (widx_d < IDX_W'(NUM_WORDS)) && (rem_d == '0);
    config_nreset_d = (state_d != S_CLEAR);
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q         <= S_IDLE;
      clr_q           <= 1'b0;
      shreg_q         <= '0;
      rem_q           <= '0;
      widx_q          <= '0;
      bits_q          <= '0;
      word_ready_q    <= 1'b0;
      config_out_q    <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_q           <= clr_d;
      shreg_q         <= shreg_d;
      rem_q           <= rem_d;
      widx_q          <= widx_d;
      bits_q          <= bits_d;
      word_ready_q    <= word_ready_d;
      config_out_q    <= config_out_d;
      config_enable_q <= config_enable_d;
      config_nreset_q <= config_nreset_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign word_ready    = word_ready_q;
  assign config_out    = config_out_q;
  assign config_enable = config_enable_q;
  assign config_nreset = config_nreset_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CONFIG_LOADER_READBACK_EN
  logic err_acc_q, err_acc_d;
  logic error_q, error_d;

  // The chain was cleared, so anything but zeros at the tail means a broken chain.
  always_comb begin
    err_acc_d = err_acc_q;
    error_d   = error_q;
    if (state_q == S_IDLE && start) begin
      err_acc_d = 1'b0;
      error_d   = 1'b0;
    end else if (state_q == S_LOAD && config_enable_q && config_in) begin
      err_acc_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      error_d = err_acc_d;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      err_acc_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      err_acc_q <= err_acc_d;
      error_q   <= error_d;
    end
  end

  assign error = error_q;
`else
  logic unused_config_in;
  assign unused_config_in = config_in;
  assign error            = 1'b0;
`endif

endmodule
